exception_ctrl: RTL and testbench
=================================

// Module: exception_ctrl
// PURPOSE
//  MEM-stage exception arbiter: the initiator side of the CP0 exception interface.
//  - Collects per-instruction exception flags and samples CP0 status/cause/epc.
//  - Commits at most one exception per cycle to CP0 as exception_type/delayslot/pc/badvaddr.
//  - Flushes the pipeline and hands fetch a redirect PC through a valid/ready handshake.
// PARAMETERS
//  EXC_VECTOR   32'hBFC0_0380  redirect target for every exception except ERET
//  ADDR_W       32             PC / address width (matches `ADDR_BUS)
// PORTS
//  clk                  in   1               clock, rising edge
//  rst                  in   1               asynchronous, active-low reset
//  mem_valid_i          in   1               MEM holds a real instruction (not a bubble)
//  mem_stall_i          in   1               MEM stalled this cycle; nothing commits
//  mem_pc_i             in   ADDR_W          PC of the MEM instruction
//  mem_delayslot_i      in   1               MEM instruction sits in a branch delay slot
//  exc_if_i             in   1               fetch address error (AdEL on PC)
//  exc_ri_i             in   1               reserved instruction
//  exc_ov_i             in   1               arithmetic overflow
//  exc_bp_i             in   1               break
//  exc_sys_i            in   1               syscall
//  exc_adel_i           in   1               load address error
//  exc_ades_i           in   1               store address error
//  eret_i               in   1               instruction is ERET
//  mem_addr_i           in   ADDR_W          data address of the load/store
//  cp0_we_i             in   1               same-cycle CP0 write, used for forwarding
//  cp0_waddr_i          in   `CP0_ADDR_BUS   same-cycle CP0 write address
//  cp0_wdata_i          in   `DATA_BUS       same-cycle CP0 write data
//  cp0_status_i         in   `DATA_BUS       CP0 Status
//  cp0_cause_i          in   `DATA_BUS       CP0 Cause
//  cp0_epc_i            in   `DATA_BUS       CP0 EPC
//  exception_type_o     out  `EXC_TYPE_BUS   to CP0 exception_type; `EXC_TYPE_NONE when idle
//  delayslot_flag_o     out  1               to CP0 delayslot_flag
//  current_pc_addr_o    out  ADDR_W          to CP0 current_pc_addr
//  badvaddr_o           out  ADDR_W          to CP0 badvaddr write data
//  flush_o              out  1               kill IF..MEM
//  redirect_valid_o     out  1               redirect_pc_o is valid
//  redirect_ready_i     in   1               fetch accepts the redirect
//  redirect_pc_o        out  ADDR_W          new fetch PC
// BEHAVIOUR
//  Reset (async, rst=0)
//   - FSM goes to IDLE; exception_type_o=NONE; flush_o=0; redirect_valid_o=0.
//   - redirect_pc_o=0, delayslot_flag_o=0, current_pc_addr_o=0, badvaddr_o=0.
//  Forwarding
//   - eff_status = cp0_wdata_i when cp0_we_i and addr==`CP0_REG_STATUS; same rule for CAUSE/EPC.
//   - Otherwise the CP0 input is used.
//  Interrupt pending
//   - int_pend = IE(bit0) & ~EXL(bit1) & |(cause[15:8] & status[15:8]), from eff_ values.
//  Commit condition
//   - commit = IDLE & mem_valid_i & ~mem_stall_i & (any flag | int_pend).
//  Priority, highest first
//   - INT > IF > RI > OV > BP > SYS > ADEL > ADES > ERET.
//   - Exactly one type is emitted per commit.
//  Outputs on the commit cycle (combinational, the same cycle CP0 samples them)
//   - exception_type_o = winner.
//   - delayslot_flag_o = mem_delayslot_i.
//   - current_pc_addr_o = mem_pc_i.
//   - badvaddr_o = mem_pc_i for IF; mem_addr_i for ADEL/ADES; otherwise 0.
//   - flush_o = 1.
//   - Registered at the edge: redirect_pc <= (ERET ? eff_epc : EXC_VECTOR), redirect_valid <= 1.
//  FSM IDLE -> REDIRECT on commit
//   - flush_o stays 1 throughout REDIRECT.
//   - exception_type_o stays NONE and all new flags are ignored (the pipeline is being killed).
//  FSM REDIRECT -> IDLE when redirect_valid_o & redirect_ready_i
//   - redirect_valid_o drops the next cycle.
//   - Commit is possible again from the next cycle.
//  Latency
//   - Flag at MEM -> flush_o in the same cycle -> redirect_valid_o in the next cycle.
//   - Minimum of 2 cycles between successive commits.
//  Boundary conditions
//   - mem_stall_i=1: no commit and no CP0 update; the exception retries when the stall releases.
//   - mem_valid_i=0: never commits, so an interrupt waits for a real instruction.
//   - ERET with EXL=0: still commits ERET and redirects to EPC.
//   - redirect_ready_i held low: stay in REDIRECT indefinitely; the PC is held stable.
//   - rst mid-REDIRECT: redirect is dropped; back to IDLE immediately.
// STRUCTURE
//  - Shared package: EXC_TYPE_* codes, CP0_REG_*, status/cause bit positions (CP0_SEG_*), EXC_VECTOR default.
//  - Encodings come from include/exception.v and include/cp0.v.
//  - One sub-module: exc_priority_enc (flags + int_pend -> type), purely combinational.
//  - The FSM and redirect registers stay in this module.
// TESTING
//  - OV at pc=0x8000_0100, ready=1: type=OV, current_pc=0x8000_0100, flush=1, next cycle redirect 0xBFC0_0380.
//  - ADES addr=0x1002, delayslot=1, pc=0x2004: type=ADES, delayslot=1, badvaddr=0x1002.
//  - RI+SYS+ADEL all set: only RI emitted; IP2 pending with IE=1, IM2=1, EXL=0 plus OV: INT wins.
//  - ERET, same cycle mtc0 EPC=0x8000_0200: redirect_pc=0x8000_0200 (forwarded), not the old EPC.
//  - Commit then ready=0 for 3 cycles: valid and PC held 4 cycles, flush=1, second exception ignored.
//  - Stall=1 with BP: type NONE; stall drops: BP commits once. rst=0 in REDIRECT: all outputs clear.

Source files
------------

// File: rtl/exception_ctrl_pkg.sv
// Shared encodings for the MEM-stage exception arbiter: exception type codes,
// CP0 register addresses, Status/Cause bit positions and the default vector.
// No logic of its own except the same-cycle CP0 forwarding helper.
package exception_ctrl_pkg;

   localparam int DATA_W     = 32;
   localparam int CP0_ADDR_W = 5;
   localparam int EXC_TYPE_W = 5;

   // Codes follow the CP0 ExcCode numbering where one exists; IF and ERET
   // get private codes so CP0 can tell them apart from data AdEL / a real trap.
   typedef enum logic [EXC_TYPE_W-1:0] {
      EXC_TYPE_INT  = 5'h00,
      EXC_TYPE_IF   = 5'h01,
      EXC_TYPE_ADEL = 5'h04,
      EXC_TYPE_ADES = 5'h05,
      EXC_TYPE_SYS  = 5'h08,
      EXC_TYPE_BP   = 5'h09,
      EXC_TYPE_RI   = 5'h0a,
      EXC_TYPE_OV   = 5'h0c,
      EXC_TYPE_ERET = 5'h0e,
      EXC_TYPE_NONE = 5'h1f
   } exc_type_t;

   localparam logic [CP0_ADDR_W-1:0] CP0_REG_STATUS = 5'd12;
   localparam logic [CP0_ADDR_W-1:0] CP0_REG_CAUSE  = 5'd13;
   localparam logic [CP0_ADDR_W-1:0] CP0_REG_EPC    = 5'd14;

   localparam int CP0_SEG_IE    = 0;
   localparam int CP0_SEG_EXL   = 1;
   localparam int CP0_SEG_IM_LO = 8;
   localparam int CP0_SEG_IM_HI = 15;
   localparam int CP0_SEG_IP_LO = 8;
   localparam int CP0_SEG_IP_HI = 15;

   localparam logic [31:0] EXC_VECTOR_DFLT = 32'hBFC0_0380;

   // Per-instruction exception flags collected at MEM.
   typedef struct packed {
      logic if_err;
      logic ri;
      logic ov;
      logic bp;
      logic sys;
      logic adel;
      logic ades;
      logic eret;
   } exc_flags_t;

   // An mtc0 retiring in the same cycle must be seen by the arbiter,
   // otherwise ERET would jump to a stale EPC.
   function automatic logic [DATA_W-1:0] cp0_fwd(
      input logic                  we,
      input logic [CP0_ADDR_W-1:0] waddr,
      input logic [DATA_W-1:0]     wdata,
      input logic [CP0_ADDR_W-1:0] reg_addr,
      input logic [DATA_W-1:0]     reg_val
   );
      return (we && (waddr == reg_addr)) ? wdata : reg_val;
   endfunction

endpackage

// File: rtl/exception_ctrl_priority_enc.sv
// Purpose: picks the single winning exception type (INT > IF > RI > OV > BP > SYS > ADEL > ADES > ERET).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the winner commits.
// Ports: flags_i (collected flags), int_pend_i (interrupt pending), exc_type_o (winner or NONE).
module exc_priority_enc
   import exception_ctrl_pkg::*;
(
   input  exc_flags_t flags_i,
   input  logic       int_pend_i,
   output exc_type_t  exc_type_o
);

   always_comb begin
      exc_type_o = EXC_TYPE_NONE;
      if (int_pend_i)          exc_type_o = EXC_TYPE_INT;
      else if (flags_i.if_err) exc_type_o = EXC_TYPE_IF;
      else if (flags_i.ri)     exc_type_o = EXC_TYPE_RI;
      else if (flags_i.ov)     exc_type_o = EXC_TYPE_OV;
      else if (flags_i.bp)     exc_type_o = EXC_TYPE_BP;
      else if (flags_i.sys)    exc_type_o = EXC_TYPE_SYS;
      else if (flags_i.adel)   exc_type_o = EXC_TYPE_ADEL;
      else if (flags_i.ades)   exc_type_o = EXC_TYPE_ADES;
      else if (flags_i.eret)   exc_type_o = EXC_TYPE_ERET;
   end

endmodule

// File: rtl/exception_ctrl.sv
// Purpose: MEM-stage exception arbiter; commits one exception to CP0, flushes, redirects fetch.
// Latency: flag -> CP0 outputs + flush same cycle; redirect_valid_o the following cycle.
// Backpressure: redirect held (valid, PC, flush) until redirect_ready_i; new flags ignored meanwhile.
// Ports: MEM instruction info + exception flags in; CP0 regs and same-cycle CP0 write in;
//        exception_type/delayslot/pc/badvaddr to CP0; flush_o; redirect valid/ready/pc to fetch.
module exception_ctrl
   import exception_ctrl_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] EXC_VECTOR = EXC_VECTOR_DFLT[ADDR_W-1:0]
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_valid_i,
   input  logic                  mem_stall_i,
   input  logic [ADDR_W-1:0]     mem_pc_i,
   input  logic                  mem_delayslot_i,
   input  logic                  exc_if_i,
   input  logic                  exc_ri_i,
   input  logic                  exc_ov_i,
   input  logic                  exc_bp_i,
   input  logic                  exc_sys_i,
   input  logic                  exc_adel_i,
   input  logic                  exc_ades_i,
   input  logic                  eret_i,
   input  logic [ADDR_W-1:0]     mem_addr_i,
   input  logic                  cp0_we_i,
   input  logic [CP0_ADDR_W-1:0] cp0_waddr_i,
   input  logic [DATA_W-1:0]     cp0_wdata_i,
   input  logic [DATA_W-1:0]     cp0_status_i,
   input  logic [DATA_W-1:0]     cp0_cause_i,
   input  logic [DATA_W-1:0]     cp0_epc_i,
   output exc_type_t             exception_type_o,
   output logic                  delayslot_flag_o,
   output logic [ADDR_W-1:0]     current_pc_addr_o,
   output logic [ADDR_W-1:0]     badvaddr_o,
   output logic                  flush_o,
   output logic                  redirect_valid_o,
   input  logic                  redirect_ready_i,
   output logic [ADDR_W-1:0]     redirect_pc_o
);

   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_REDIRECT = 1'b1;

   logic [0:0]        state;
   logic [DATA_W-1:0] eff_status;
   logic [DATA_W-1:0] eff_cause;
   logic [DATA_W-1:0] eff_epc;
   logic              int_pend;
   exc_flags_t        flags;
   exc_type_t         winner;
   logic              commit;

   assign eff_status = cp0_fwd(cp0_we_i, cp0_waddr_i, cp0_wdata_i, CP0_REG_STATUS, cp0_status_i);
   assign eff_cause  = cp0_fwd(cp0_we_i, cp0_waddr_i, cp0_wdata_i, CP0_REG_CAUSE,  cp0_cause_i);
   assign eff_epc    = cp0_fwd(cp0_we_i, cp0_waddr_i, cp0_wdata_i, CP0_REG_EPC,    cp0_epc_i);

   assign int_pend = eff_status[CP0_SEG_IE] & ~eff_status[CP0_SEG_EXL] &
                     (|(eff_cause[CP0_SEG_IP_HI:CP0_SEG_IP_LO] &
                        eff_status[CP0_SEG_IM_HI:CP0_SEG_IM_LO]));

   assign flags = '{if_err: exc_if_i, ri: exc_ri_i, ov: exc_ov_i, bp: exc_bp_i,
                    sys: exc_sys_i, adel: exc_adel_i, ades: exc_ades_i, eret: eret_i};

   exc_priority_enc u_prio (
      .flags_i    (flags),
      .int_pend_i (int_pend),
      .exc_type_o (winner)
   );

   // rst is folded in so CP0 sees NONE and no flush while reset is held,
   // even though the FSM already sits in IDLE.
   assign commit = rst & (state == ST_IDLE) & mem_valid_i & ~mem_stall_i &
                   (winner != EXC_TYPE_NONE);

   always_comb begin
      exception_type_o  = EXC_TYPE_NONE;
      delayslot_flag_o  = 1'b0;
      current_pc_addr_o = '0;
      badvaddr_o        = '0;
      if (commit) begin
         exception_type_o  = winner;
         delayslot_flag_o  = mem_delayslot_i;
         current_pc_addr_o = mem_pc_i;
         if (winner == EXC_TYPE_IF)
            badvaddr_o = mem_pc_i;
         else if ((winner == EXC_TYPE_ADEL) || (winner == EXC_TYPE_ADES))
            badvaddr_o = mem_addr_i;
      end
   end

   // The pipeline stays killed for the whole redirect so nothing younger
   // than the faulting instruction can retire before fetch turns around.
   assign flush_o = commit | (state == ST_REDIRECT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= ST_IDLE;
         redirect_valid_o <= 1'b0;
         redirect_pc_o    <= '0;
      end else if (state == ST_IDLE) begin
         if (commit) begin
            state            <= ST_REDIRECT;
            redirect_valid_o <= 1'b1;
            redirect_pc_o    <= (winner == EXC_TYPE_ERET) ? eff_epc[ADDR_W-1:0] : EXC_VECTOR;
         end
      end else begin
         if (redirect_valid_o && redirect_ready_i) begin
            state            <= ST_IDLE;
            redirect_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: table of single-commit vectors, hand sequences for
// stall / held-ready / reset corners, then randomized traffic against a reference model.
module tb_exception_ctrl;
   import exception_ctrl_pkg::*;

   localparam logic [31:0] VEC = 32'hBFC0_0380;
   // flag bit positions: [7]=IF [6]=RI [5]=OV [4]=BP [3]=SYS [2]=ADEL [1]=ADES [0]=ERET
   localparam logic [7:0] F_IF = 8'h80, F_RI = 8'h40, F_OV = 8'h20, F_BP = 8'h10;
   localparam logic [7:0] F_SYS = 8'h08, F_ADEL = 8'h04, F_ADES = 8'h02, F_ERET = 8'h01;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, mem_stall, mem_ds;
   logic [31:0] mem_pc, mem_addr;
   logic [7:0]  fl;
   logic        cp0_we;
   logic [4:0]  cp0_waddr;
   logic [31:0] cp0_wdata, cp0_status, cp0_cause, cp0_epc;
   exc_type_t   exc_type;
   logic        ds_flag, flush, rvalid, rready;
   logic [31:0] cur_pc, badv, rpc;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   exception_ctrl dut (
      .clk(clk), .rst(rst),
      .mem_valid_i(mem_valid), .mem_stall_i(mem_stall), .mem_pc_i(mem_pc),
      .mem_delayslot_i(mem_ds),
      .exc_if_i(fl[7]), .exc_ri_i(fl[6]), .exc_ov_i(fl[5]), .exc_bp_i(fl[4]),
      .exc_sys_i(fl[3]), .exc_adel_i(fl[2]), .exc_ades_i(fl[1]), .eret_i(fl[0]),
      .mem_addr_i(mem_addr),
      .cp0_we_i(cp0_we), .cp0_waddr_i(cp0_waddr), .cp0_wdata_i(cp0_wdata),
      .cp0_status_i(cp0_status), .cp0_cause_i(cp0_cause), .cp0_epc_i(cp0_epc),
      .exception_type_o(exc_type), .delayslot_flag_o(ds_flag),
      .current_pc_addr_o(cur_pc), .badvaddr_o(badv), .flush_o(flush),
      .redirect_valid_o(rvalid), .redirect_ready_i(rready), .redirect_pc_o(rpc)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      mem_valid = 1'b0; mem_stall = 1'b0; mem_ds = 1'b0; mem_pc = '0; mem_addr = '0;
      fl = '0; cp0_we = 1'b0; cp0_waddr = '0; cp0_wdata = '0;
      cp0_status = '0; cp0_cause = '0; cp0_epc = '0; rready = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic exc_type_t ref_winner(input bit intp, input logic [7:0] f);
      exc_type_t order [9];
      bit        req   [9];
      order = '{EXC_TYPE_INT, EXC_TYPE_IF, EXC_TYPE_RI, EXC_TYPE_OV, EXC_TYPE_BP,
                EXC_TYPE_SYS, EXC_TYPE_ADEL, EXC_TYPE_ADES, EXC_TYPE_ERET};
      req[0] = intp;
      for (int i = 0; i < 8; i++) req[i+1] = f[7-i];
      for (int i = 0; i < 9; i++) if (req[i]) return order[i];
      return EXC_TYPE_NONE;
   endfunction

   bit          m_busy;
   logic [31:0] m_rpc;

   task automatic model_step();
      logic [31:0] es, ec, ee, e_badv;
      bit          intp, commit;
      exc_type_t   w;
      es = (cp0_we && cp0_waddr == 5'd12) ? cp0_wdata : cp0_status;
      ec = (cp0_we && cp0_waddr == 5'd13) ? cp0_wdata : cp0_cause;
      ee = (cp0_we && cp0_waddr == 5'd14) ? cp0_wdata : cp0_epc;
      intp = es[0] && !es[1] && ((ec[15:8] & es[15:8]) != 8'h00);
      w = ref_winner(intp, fl);
      commit = !m_busy && mem_valid && !mem_stall && (w != EXC_TYPE_NONE);
      e_badv = 32'h0;
      if (commit && w == EXC_TYPE_IF) e_badv = mem_pc;
      if (commit && (w == EXC_TYPE_ADEL || w == EXC_TYPE_ADES)) e_badv = mem_addr;
      @(negedge clk);
      chk("rnd_type",   exc_type, commit ? w : EXC_TYPE_NONE);
      chk("rnd_ds",     ds_flag,  commit ? mem_ds : 1'b0);
      chk("rnd_pc",     cur_pc,   commit ? mem_pc : 32'h0);
      chk("rnd_badv",   badv,     e_badv);
      chk("rnd_flush",  flush,    commit || m_busy);
      chk("rnd_rvalid", rvalid,   m_busy);
      chk("rnd_rpc",    rpc,      m_rpc);
      @(posedge clk);
      if (commit) begin
         m_busy = 1'b1;
         m_rpc  = (w == EXC_TYPE_ERET) ? ee : VEC;
      end else if (m_busy && rready) begin
         m_busy = 1'b0;
      end
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0]  fl;
      logic [31:0] pc, addr;
      logic        ds;
      logic [31:0] status, cause, epc;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      exc_type_t   e_type;
      logic [31:0] e_badv, e_rpc;
   } vec_t;

   vec_t tbl[$];

   initial begin
      idle_inputs();
      rst = 1'b0;
      tbl.push_back('{F_OV, 32'h8000_0100, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, EXC_TYPE_OV, 32'h0, VEC});
      tbl.push_back('{F_ADES, 32'h0000_2004, 32'h0000_1002, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, EXC_TYPE_ADES, 32'h0000_1002, VEC});
      tbl.push_back('{F_RI|F_SYS|F_ADEL, 32'h8000_0040, 32'h3, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, EXC_TYPE_RI, 32'h0, VEC});
      tbl.push_back('{F_OV, 32'h8000_0300, 32'h0, 1'b0, 32'h401, 32'h400, 32'h0, 1'b0, 5'd0, 32'h0, EXC_TYPE_INT, 32'h0, VEC});
      tbl.push_back('{F_ERET, 32'h8000_0400, 32'h0, 1'b0, 32'h2, 32'h0, 32'h1234_5678, 1'b1, 5'd14, 32'h8000_0200, EXC_TYPE_ERET, 32'h0, 32'h8000_0200});
      tbl.push_back('{F_IF, 32'h8000_0003, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, EXC_TYPE_IF, 32'h8000_0003, VEC});
      tbl.push_back('{F_ADEL, 32'h8000_0500, 32'hDEAD_BEE1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, EXC_TYPE_ADEL, 32'hDEAD_BEE1, VEC});
      tbl.push_back('{8'h00, 32'h8000_0600, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, EXC_TYPE_NONE, 32'h0, 32'h0});
      tbl.push_back('{8'h00, 32'h8000_0700, 32'h0, 1'b0, 32'h403, 32'h400, 32'h0, 1'b0, 5'd0, 32'h0, EXC_TYPE_NONE, 32'h0, 32'h0});
      tbl.push_back('{F_ERET, 32'h8000_0800, 32'h0, 1'b0, 32'h0, 32'h0, 32'h8000_1000, 1'b0, 5'd0, 32'h0, EXC_TYPE_ERET, 32'h0, 32'h8000_1000});
      tbl.push_back('{F_BP, 32'h8000_0900, 32'h0, 1'b0, 32'h0, 32'h400, 32'h0, 1'b1, 5'd12, 32'h401, EXC_TYPE_INT, 32'h0, VEC});
      tbl.push_back('{F_BP|F_SYS|F_ADES|F_ERET, 32'h8000_0A00, 32'h44, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, EXC_TYPE_BP, 32'h0, VEC});
      tbl.push_back('{F_ADES|F_ERET, 32'h8000_0B00, 32'h7, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, EXC_TYPE_ADES, 32'h7, VEC});
      tbl.push_back('{8'h00, 32'h8000_0C00, 32'h0, 1'b0, 32'h801, 32'h0, 32'h0, 1'b1, 5'd13, 32'h800, EXC_TYPE_INT, 32'h0, VEC});

      // reset state
      #2;
      chk("rst_type", exc_type, EXC_TYPE_NONE);
      chk("rst_flush", flush, 1'b0);
      chk("rst_rvalid", rvalid, 1'b0);
      chk("rst_rpc", rpc, 32'h0);
      chk("rst_ds", ds_flag, 1'b0);
      chk("rst_pc", cur_pc, 32'h0);
      chk("rst_badv", badv, 32'h0);
      tick();
      rst = 1'b1;

      // table: each row committed from IDLE with fetch ready
      foreach (tbl[i]) begin
         mem_valid = 1'b1; mem_stall = 1'b0; rready = 1'b1;
         fl = tbl[i].fl; mem_pc = tbl[i].pc; mem_addr = tbl[i].addr; mem_ds = tbl[i].ds;
         cp0_status = tbl[i].status; cp0_cause = tbl[i].cause; cp0_epc = tbl[i].epc;
         cp0_we = tbl[i].we; cp0_waddr = tbl[i].waddr; cp0_wdata = tbl[i].wdata;
         @(negedge clk);
         chk("tbl_type", exc_type, tbl[i].e_type);
         chk("tbl_flush", flush, tbl[i].e_type != EXC_TYPE_NONE);
         chk("tbl_rvalid0", rvalid, 1'b0);
         if (tbl[i].e_type != EXC_TYPE_NONE) begin
            chk("tbl_ds", ds_flag, tbl[i].ds);
            chk("tbl_pc", cur_pc, tbl[i].pc);
            chk("tbl_badv", badv, tbl[i].e_badv);
         end
         tick();
         idle_inputs();
         @(negedge clk);
         chk("tbl_rvalid1", rvalid, tbl[i].e_type != EXC_TYPE_NONE);
         if (tbl[i].e_type != EXC_TYPE_NONE) begin
            chk("tbl_rpc", rpc, tbl[i].e_rpc);
            chk("tbl_flush1", flush, 1'b1);
            chk("tbl_type1", exc_type, EXC_TYPE_NONE);
         end
         tick();
      end

      // ready held low for 3 cycles: valid/PC/flush held, later exception ignored
      mem_valid = 1'b1; fl = F_OV; mem_pc = 32'h8000_0100; rready = 1'b0;
      @(negedge clk);
      chk("hold_commit", exc_type, EXC_TYPE_OV);
      tick();
      fl = F_BP; mem_pc = 32'h8000_0104;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) rready = 1'b1;
         @(negedge clk);
         chk("hold_rvalid", rvalid, 1'b1);
         chk("hold_rpc", rpc, VEC);
         chk("hold_flush", flush, 1'b1);
         chk("hold_type", exc_type, EXC_TYPE_NONE);
         tick();
      end
      idle_inputs();
      @(negedge clk);
      chk("hold_release", rvalid, 1'b0);
      chk("hold_unflush", flush, 1'b0);
      tick();

      // stall suppresses commit; BP commits once when it releases
      mem_valid = 1'b1; mem_stall = 1'b1; fl = F_BP; mem_pc = 32'h8000_0D00;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("stall_type", exc_type, EXC_TYPE_NONE);
         chk("stall_flush", flush, 1'b0);
         tick();
      end
      mem_stall = 1'b0;
      @(negedge clk);
      chk("unstall_type", exc_type, EXC_TYPE_BP);
      chk("unstall_pc", cur_pc, 32'h8000_0D00);
      tick();
      @(negedge clk);
      chk("unstall_once", exc_type, EXC_TYPE_NONE);
      chk("unstall_rvalid", rvalid, 1'b1);
      tick();
      idle_inputs();

      // interrupt waits for a real instruction
      cp0_status = 32'h401; cp0_cause = 32'h400; mem_valid = 1'b0;
      @(negedge clk);
      chk("bubble_int", exc_type, EXC_TYPE_NONE);
      tick();
      mem_valid = 1'b1; mem_pc = 32'h8000_0E00;
      @(negedge clk);
      chk("real_int", exc_type, EXC_TYPE_INT);
      tick();
      idle_inputs();
      tick();

      // reset while in REDIRECT, flags still present
      mem_valid = 1'b1; fl = F_SYS; mem_pc = 32'h8000_0F00; rready = 1'b0;
      tick();
      @(negedge clk);
      chk("prerst_rvalid", rvalid, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("midrst_rvalid", rvalid, 1'b0);
      chk("midrst_rpc", rpc, 32'h0);
      chk("midrst_flush", flush, 1'b0);
      chk("midrst_type", exc_type, EXC_TYPE_NONE);
      chk("midrst_pc", cur_pc, 32'h0);
      idle_inputs();
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("postrst_rvalid", rvalid, 1'b0);
      tick();

      // randomized traffic against the model
      m_busy = 1'b0;
      m_rpc  = 32'h0;
      for (int n = 0; n < 400; n++) begin
         logic [4:0] regs [4];
         regs = '{5'd12, 5'd13, 5'd14, 5'd3};
         mem_valid  = ($urandom_range(3) != 0);
         mem_stall  = ($urandom_range(3) == 0);
         mem_ds     = $urandom_range(1);
         mem_pc     = $urandom;
         mem_addr   = $urandom;
         for (int b = 0; b < 8; b++) fl[b] = ($urandom_range(7) == 0);
         cp0_status = $urandom;
         cp0_cause  = $urandom;
         cp0_epc    = $urandom;
         cp0_we     = ($urandom_range(3) == 0);
         cp0_waddr  = regs[$urandom_range(3)];
         cp0_wdata  = $urandom;
         rready     = ($urandom_range(2) != 0);
         model_step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
